// File: rtl/light_pkg.sv
// Shared definitions for the light_bank channel controllers.
//   MODE_RISE / MODE_ANY : values for the light_bank MODE parameter
//   light_mode_t         : decoded toggle mode used inside the bank
package light_pkg;

  localparam int unsigned MODE_RISE = 0;
  localparam int unsigned MODE_ANY  = 1;

  typedef enum logic {
    LM_RISE = 1'b0,
    LM_ANY  = 1'b1
  } light_mode_t;

  // Decides whether an accepted debounce change flips the light.
  // stable_q is the value before the accept, so a rise means it was 0.
  function automatic logic light_event(light_mode_t mode, logic accept, logic stable_q);
    return accept & ((mode == LM_ANY) | ~stable_q);
  endfunction

endpackage

// File: rtl/light_debounce.sv
// One light channel front end: 2-flop synchroniser per switch,
// XOR combine, and a consecutive-cycle debounce counter.
//   clk, rst_n   : clock, async active-low reset
//   sw_i         : raw switch levels for this channel
//   stable_o     : debounced parity (registered)
//   accept_c_o   : high in the cycle whose edge updates stable_o (combinational)
module light_debounce
  import light_pkg::*;
#(
  parameter int unsigned NSW    = 2,
  parameter int unsigned DB_CNT = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NSW-1:0] sw_i,
  output logic           stable_o,
  output logic           accept_c_o
);

  localparam int unsigned CW       = $clog2(DB_CNT + 1);
  localparam int unsigned CNT_LAST = DB_CNT - 1;

  logic [NSW-1:0] s1_q;
  logic [NSW-1:0] s2_q;
  logic           raw_c;
  logic           stable_q;
  logic           stable_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;

  // Metastability synchroniser, one pair of flops per switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

  // Any single switch flip changes the request.
  assign raw_c = ^s2_q;

  // Count consecutive cycles of disagreement; any agreement restarts.
  always_comb begin
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    accept_c_o = 1'b0;
    if (raw_c == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CNT_LAST)) begin
      stable_d   = raw_c;
      cnt_d      = '0;
      accept_c_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/light_bank.sv
// Bank of CH independent multi-way light controllers.
//   clk, rst_n : clock, async active-low reset
//   sw         : CH*NSW raw switch levels, channel c uses sw[c*NSW +: NSW]
//   clr        : per-channel synchronous clear of light to INIT
//   light      : registered light state per channel
//   toggled    : registered one-cycle pulse after each light flip
module light_bank
  import light_pkg::*;
#(
  parameter int unsigned CH     = 4,
  parameter int unsigned NSW    = 2,
  parameter int unsigned DB_CNT = 1000,
  parameter int unsigned MODE   = MODE_RISE,
  parameter logic        INIT   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*NSW-1:0] sw,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     light,
  output logic [CH-1:0]     toggled
);

  localparam light_mode_t MODE_E = (MODE == MODE_ANY) ? LM_ANY : LM_RISE;

  logic [CH-1:0] stable_w;
  logic [CH-1:0] accept_c;
  logic [CH-1:0] light_q;
  logic [CH-1:0] light_d;
  logic [CH-1:0] toggled_q;
  logic [CH-1:0] toggled_d;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    light_debounce #(
      .NSW    (NSW),
      .DB_CNT (DB_CNT)
    ) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_i       (sw[c*NSW +: NSW]),
      .stable_o   (stable_w[c]),
      .accept_c_o (accept_c[c])
    );
  end

  // Clear beats a coincident event; the debouncer still advances.
  always_comb begin
    light_d   = light_q;
    toggled_d = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (clr[c]) begin
        light_d[c] = INIT;
      end else if (light_event(MODE_E, accept_c[c], stable_w[c])) begin
        light_d[c]   = ~light_q[c];
        toggled_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_q   <= {CH{INIT}};
      toggled_q <= '0;
    end else begin
      light_q   <= light_d;
      toggled_q <= toggled_d;
    end
  end

  assign light   = light_q;
  assign toggled = toggled_q;

endmodule

// File: tb/tb_light_bank.sv
// Randomised and directed check of light_bank in both toggle modes
// against a window-based behavioural model.
module tb_light_bank;
  import light_pkg::*;

  localparam int unsigned CH     = 4;
  localparam int unsigned NSW    = 2;
  localparam int unsigned DB_CNT = 4;
  localparam logic        INIT   = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH*NSW-1:0] sw = '0;
  logic [CH-1:0]     clr = '0;
  logic [CH-1:0]     light_rise, tog_rise, light_any, tog_any;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  light_bank #(.CH(CH), .NSW(NSW), .DB_CNT(DB_CNT), .MODE(MODE_RISE), .INIT(INIT)) u_rise (
    .clk(clk), .rst_n(rst_n), .sw(sw), .clr(clr), .light(light_rise), .toggled(tog_rise));

  light_bank #(.CH(CH), .NSW(NSW), .DB_CNT(DB_CNT), .MODE(MODE_ANY), .INIT(INIT)) u_any (
    .clk(clk), .rst_n(rst_n), .sw(sw), .clr(clr), .light(light_any), .toggled(tog_any));

  // Reference model: switches reach the parity after two clocks; a new
  // parity is accepted once the last DB_CNT sampled parities all differ
  // from the current debounced value.
  logic [CH*NSW-1:0] m_s1, m_s2;
  logic [DB_CNT-1:0] m_win [CH];
  logic [CH-1:0]     m_stable;
  logic [CH-1:0]     m_light [2];
  logic [CH-1:0]     m_tog [2];

  always @(posedge clk or negedge rst_n) begin : model
    logic              par;
    logic [DB_CNT-1:0] win;
    logic              acc;
    logic              ev;
    if (!rst_n) begin
      m_s1       <= '0;
      m_s2       <= '0;
      m_stable   <= '0;
      m_light[0] <= {CH{INIT}};
      m_light[1] <= {CH{INIT}};
      m_tog[0]   <= '0;
      m_tog[1]   <= '0;
      for (int c = 0; c < CH; c++) m_win[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        par = 1'b0;
        for (int k = 0; k < NSW; k++) par = par ^ m_s2[c*NSW + k];
        win = {m_win[c][DB_CNT-2:0], par};
        acc = (win == {DB_CNT{~m_stable[c]}});
        m_win[c] <= win;
        if (acc) m_stable[c] <= par;
        for (int m = 0; m < 2; m++) begin
          ev = acc && ((m == 1) || par);
          if (clr[c]) begin
            m_light[m][c] <= INIT;
            m_tog[m][c]   <= 1'b0;
          end else if (ev) begin
            m_light[m][c] <= ~m_light[m][c];
            m_tog[m][c]   <= 1'b1;
          end else begin
            m_tog[m][c]   <= 1'b0;
          end
        end
      end
      m_s2 <= m_s1;
      m_s1 <= sw;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("light_rise", 32'(light_rise), 32'(m_light[0]));
    check("tog_rise",   32'(tog_rise),   32'(m_tog[0]));
    check("light_any",  32'(light_any),  32'(m_light[1]));
    check("tog_any",    32'(tog_any),    32'(m_tog[1]));
  endtask

  // Advance one edge, then sample away from it.
  task automatic step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset holds the lights at INIT while the clock runs.
    #2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_light_any", 32'(light_any), 32'hF);
      check("rst_tog_any",   32'(tog_any),   32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst_light", 32'(light_rise), 32'hF);
      check("post_rst_tog",   32'(tog_rise),   32'h0);
    end

    // 00 -> 01 on channel 0: flip at edge 6.
    sw[1:0] = 2'b01;
    steps(5);
    check("ch0_edge5", 32'(light_any[0]), 32'd1);
    step();
    check("ch0_edge6_any",  32'(light_any[0]), 32'd0);
    check("ch0_edge6_tog",  32'(tog_any[0]),   32'd1);
    check("ch0_edge6_rise", 32'(light_rise[0]), 32'd0);
    step();
    check("ch0_tog_one", 32'(tog_any[0]), 32'd0);
    steps(4);

    // 01 -> 11: parity falls; only MODE_ANY toggles.
    sw[1:0] = 2'b11;
    steps(6);
    check("ch0_fall_any",  32'(light_any[0]),  32'd1);
    check("ch0_fall_rise", 32'(light_rise[0]), 32'd0);
    check("ch0_fall_trise", 32'(tog_rise[0]),  32'd0);
    steps(4);

    // 3-cycle glitch on channel 1: rejected.
    sw[2] = 1'b1;
    steps(3);
    sw[2] = 1'b0;
    steps(10);
    check("glitch3_any", 32'(light_any[1]), 32'd1);
    // 4-cycle pulse: accepted both ways.
    sw[2] = 1'b1;
    steps(4);
    sw[2] = 1'b0;
    steps(12);
    check("pulse4_any",  32'(light_any[1]),  32'd1);
    check("pulse4_rise", 32'(light_rise[1]), 32'd0);

    // Clear on the same edge as a channel-2 event.
    sw[5:4] = 2'b01;
    steps(5);
    clr[2] = 1'b1;
    step();
    clr = '0;
    check("clr_light", 32'(light_any[2]), 32'd1);
    check("clr_tog",   32'(tog_any[2]),   32'd0);
    check("clr_ch3",   32'(light_any[3]), 32'd1);
    steps(4);
    sw[5:4] = 2'b11;
    steps(6);
    check("after_clr_any",  32'(light_any[2]),  32'd0);
    check("after_clr_rise", 32'(light_rise[2]), 32'd1);
    steps(4);

    // Reset mid-count with odd parity held on channels 2 and 3.
    sw = 8'b0101_0000;
    steps(4);
    rst_n = 1'b0;
    steps(3);
    check("rst_mid_light", 32'(light_any), 32'hF);
    rst_n = 1'b1;
    steps(5);
    check("rel_edge5", 32'(light_any[3:2]), 32'b11);
    step();
    check("rel_edge6_any",  32'(light_any[3:2]),  32'b00);
    check("rel_edge6_rise", 32'(light_rise[3:2]), 32'b00);
    steps(4);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int idx;
        idx = $urandom_range(0, CH*NSW-1);
        sw[idx] = ~sw[idx];
      end
      clr = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
